// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- receive-side sequencer for the UART.
//
// Finds the start edge on the serial line, runs the datapath bit timer, and
// strobes the rx shift register once per data/parity bit. It checks the stop
// bits, tracks an all-zero (break) frame, and issues a one-cycle done at the
// end of each frame.
//
// Optional build macro:
//   UART_RX_START_CHECK_EN  reject a start bit whose mid-sample is 1
//                           (pulses false_start, returns to IDLE).
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx_enable       CSR receiver enable, only looked at in IDLE
//   rx              raw asynchronous serial line
//   rx_bit          datapath mid-bit sample, valid with wait_bit_done
//   wait_bit_done   end-of-bit pulse from the datapath timer
//   data_bits       CSR data bit count (5..8, anything else means 8)
//   parity_en       CSR parity bit present
//   two_stop        CSR two stop bits
//   wait_bit_en     timer enable
//   wait_bit_rst_n  timer clear, active low
//   shift_bits      one-cycle shift strobe per data/parity bit
//   done            one-cycle frame-complete strobe
//   busy            frame in progress
//   framing_error   with done: a stop bit sampled 0
//   break_detect    with done: every sample of the frame was 0
//   false_start     start bit rejected (0 unless UART_RX_START_CHECK_EN)
module uart_rx_ctrl #(
    parameter int unsigned DATA_BITS_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_enable,
    input  logic                   rx,
    input  logic                   rx_bit,
    input  logic                   wait_bit_done,
    input  logic [DATA_BITS_W-1:0] data_bits,
    input  logic                   parity_en,
    input  logic                   two_stop,
    output logic                   wait_bit_en,
    output logic                   wait_bit_rst_n,
    output logic                   shift_bits,
    output logic                   done,
    output logic                   busy,
    output logic                   framing_error,
    output logic                   break_detect,
    output logic                   false_start
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_FINISH
    } state_t;

    state_t     state_q, state_d;
    logic       rx_meta, rx_s, rx_s_d;
    logic       rx_fall;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] last_bit_q, last_bit_d;
    logic       par_q, par_d;
    logic       two_q, two_d;
    logic       stop_err_q, stop_err_d;
    logic       all_zero_q, all_zero_d;
    logic       shift_d, done_d, fe_d, brk_d, fs_d;
    logic       data_bits_legal;

    // Synchronizer flops reset to the idle (mark) level so reset itself
    // never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign rx_fall = rx_s_d & ~rx_s;

    assign data_bits_legal = (data_bits >= DATA_BITS_W'(5)) &&
                             (data_bits <= DATA_BITS_W'(8));

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        last_bit_d = last_bit_q;
        par_d      = par_q;
        two_d      = two_q;
        stop_err_d = stop_err_q;
        all_zero_d = all_zero_q;
        shift_d    = 1'b0;
        done_d     = 1'b0;
        fe_d       = 1'b0;
        brk_d      = 1'b0;
        fs_d       = 1'b0;

        // Any 1 sample anywhere in the frame rules out a break.
        if (state_q != S_IDLE && wait_bit_done && rx_bit) begin
            all_zero_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (rx_enable && rx_fall) begin
                    state_d    = S_START;
                    // Index of the final data bit; 8 bits wraps to 3'd7.
                    last_bit_d = data_bits_legal ? (data_bits[2:0] - 3'd1) : 3'd7;
                    par_d      = parity_en;
                    two_d      = two_stop;
                    stop_err_d = 1'b0;
                    all_zero_d = 1'b1;
                end
            end
            S_START: begin
                if (wait_bit_done) begin
`ifdef UART_RX_START_CHECK_EN
                    if (rx_bit) begin
                        fs_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
`else
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
`endif
                end
            end
            S_DATA: begin
                if (wait_bit_done) begin
                    shift_d   = 1'b1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == last_bit_q) begin
                        state_d = par_q ? S_PARITY : S_STOP1;
                    end
                end
            end
            S_PARITY: begin
                if (wait_bit_done) begin
                    shift_d = 1'b1;
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (wait_bit_done) begin
                    stop_err_d = ~rx_bit;
                    if (two_q) begin
                        state_d = S_STOP2;
                    end else begin
                        // Strobes are registered, so they land in FINISH.
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                        fe_d    = ~rx_bit;
                        brk_d   = all_zero_q & ~rx_bit;
                    end
                end
            end
            S_STOP2: begin
                if (wait_bit_done) begin
                    stop_err_d = stop_err_q | ~rx_bit;
                    state_d    = S_FINISH;
                    done_d     = 1'b1;
                    fe_d       = stop_err_q | ~rx_bit;
                    brk_d      = all_zero_q & ~rx_bit;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            last_bit_q    <= '0;
            par_q         <= 1'b0;
            two_q         <= 1'b0;
            stop_err_q    <= 1'b0;
            all_zero_q    <= 1'b0;
            shift_bits    <= 1'b0;
            done          <= 1'b0;
            framing_error <= 1'b0;
            break_detect  <= 1'b0;
            false_start   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            last_bit_q    <= last_bit_d;
            par_q         <= par_d;
            two_q         <= two_d;
            stop_err_q    <= stop_err_d;
            all_zero_q    <= all_zero_d;
            shift_bits    <= shift_d;
            done          <= done_d;
            framing_error <= fe_d;
            break_detect  <= brk_d;
            false_start   <= fs_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign wait_bit_en    = busy;
    assign wait_bit_rst_n = busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl. A small timer/line model inside the
// tick task plays the rx datapath: it runs a 16-cycle bit timer while
// wait_bit_en is high and presents each frame bit on rx_bit at wait_bit_done.
module tb_uart_rx_ctrl;

    localparam int PERIOD = 16;

    logic       clk;
    logic       rst;
    logic       rx_enable;
    logic       rx;
    logic       rx_bit;
    logic       wait_bit_done;
    logic [3:0] data_bits;
    logic       parity_en;
    logic       two_stop;
    logic       wait_bit_en;
    logic       wait_bit_rst_n;
    logic       shift_bits;
    logic       done;
    logic       busy;
    logic       framing_error;
    logic       break_detect;
    logic       false_start;

    uart_rx_ctrl #(.DATA_BITS_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_enable      (rx_enable),
        .rx             (rx),
        .rx_bit         (rx_bit),
        .wait_bit_done  (wait_bit_done),
        .data_bits      (data_bits),
        .parity_en      (parity_en),
        .two_stop       (two_stop),
        .wait_bit_en    (wait_bit_en),
        .wait_bit_rst_n (wait_bit_rst_n),
        .shift_bits     (shift_bits),
        .done           (done),
        .busy           (busy),
        .framing_error  (framing_error),
        .break_detect   (break_detect),
        .false_start    (false_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] db;        // CSR data_bits value
        int         nd;        // data bits actually on the line
        logic       par;
        logic       two;
        logic [7:0] data;
        logic       pv;        // parity bit value on the line
        logic       s1;
        logic       s2;
        int         perturb;   // 0 none, 1 drop rx_enable, 2 change CSRs
        int         exp_shift;
        int         exp_fe;
        int         exp_brk;
        int         exp_len;   // cycles from START to done
    } vec_t;

    vec_t tbl [7];

    // Line model state (written only by the main process).
    logic [15:0] line_bits;
    int          nbits;
    logic        idle_level;
    int          tcnt;
    int          bit_idx;

    // Monitor state (written only by the monitor process).
    int   cyc, shift_total, done_total, fe_total, brk_total, fs_total;
    int   start_total, misalign, orphan, start_cyc, done_cyc;
    logic wbd_last, busy_last;

    int checks;
    int failures;
    int s_shift, s_done, s_fe, s_brk, s_start, s_fs;

    initial begin
        cyc = 0; shift_total = 0; done_total = 0; fe_total = 0; brk_total = 0;
        fs_total = 0; start_total = 0; misalign = 0; orphan = 0;
        start_cyc = 0; done_cyc = 0; wbd_last = 1'b0; busy_last = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy && !busy_last) begin
                start_total++;
                start_cyc = cyc;
            end
            if (shift_bits) begin
                shift_total++;
                if (!wbd_last) misalign++;
            end
            if (done) begin
                done_total++;
                done_cyc = cyc;
                if (!wbd_last) misalign++;
            end
            if (framing_error) begin
                fe_total++;
                if (!done) orphan++;
            end
            if (break_detect) begin
                brk_total++;
                if (!done) orphan++;
            end
            if (false_start) fs_total++;
            wbd_last  = wait_bit_done;
            busy_last = busy;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wait_bit_done = 1'b0;
        if (!wait_bit_en) begin
            tcnt    = 0;
            bit_idx = 0;
        end else begin
            tcnt++;
            if (tcnt == PERIOD) begin
                tcnt          = 0;
                wait_bit_done = 1'b1;
                rx_bit        = (bit_idx < 16) ? line_bits[bit_idx] : idle_level;
                bit_idx++;
                rx            = (bit_idx < nbits) ? line_bits[bit_idx] : idle_level;
            end
        end
    endtask

    task automatic load_line(input vec_t v);
        line_bits = '0;
        nbits     = 1;
        for (int i = 0; i < v.nd; i++) begin
            line_bits[nbits] = v.data[i];
            nbits++;
        end
        if (v.par) begin
            line_bits[nbits] = v.pv;
            nbits++;
        end
        line_bits[nbits] = v.s1;
        nbits++;
        if (v.two) begin
            line_bits[nbits] = v.s2;
            nbits++;
        end
        idle_level = 1'b1;
    endtask

    task automatic snapshot();
        s_shift = shift_total;
        s_done  = done_total;
        s_fe    = fe_total;
        s_brk   = brk_total;
        s_start = start_total;
        s_fs    = fs_total;
    endtask

    task automatic start_frame(input vec_t v);
        data_bits = v.db;
        parity_en = v.par;
        two_stop  = v.two;
        rx_enable = 1'b1;
        load_line(v);
        rx = 1'b1;
        repeat (4) tick();
        snapshot();
        rx = 1'b0;
        tick();
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 600 && done_total == s_done; i++) tick();
        chk({name, " done seen"}, (done_total != s_done) ? 1 : 0, 1);
        repeat (3) tick();
    endtask

    task automatic run_vec(input int k);
        vec_t  v;
        string n;
        v = tbl[k];
        n = $sformatf("v%0d", k);
        start_frame(v);
        if (v.perturb != 0) begin
            repeat (20) tick();
            if (v.perturb == 1) begin
                rx_enable = 1'b0;
            end else begin
                data_bits = 4'd5;
                parity_en = ~v.par;
                two_stop  = ~v.two;
            end
        end
        wait_done(n);
        chk({n, " shifts"}, shift_total - s_shift, v.exp_shift);
        chk({n, " done_count"}, done_total - s_done, 1);
        chk({n, " framing_error"}, fe_total - s_fe, v.exp_fe);
        chk({n, " break_detect"}, brk_total - s_brk, v.exp_brk);
        chk({n, " frame_len"}, done_cyc - start_cyc, v.exp_len);
        chk({n, " idle_after"}, {busy, wait_bit_en, wait_bit_rst_n}, 0);
        rx_enable = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; rx_enable = 1'b1; rx = 1'b1; rx_bit = 1'b1;
        wait_bit_done = 1'b0; data_bits = 4'd8; parity_en = 1'b0; two_stop = 1'b0;
        line_bits = '1; nbits = 0; idle_level = 1'b1; tcnt = 0; bit_idx = 0;

        tbl[0] = '{db:4'd8,  nd:8, par:1'b0, two:1'b0, data:8'h55, pv:1'b0, s1:1'b1, s2:1'b1,
                   perturb:1, exp_shift:8, exp_fe:0, exp_brk:0, exp_len:160};
        tbl[1] = '{db:4'd7,  nd:7, par:1'b1, two:1'b1, data:8'h41, pv:1'b0, s1:1'b1, s2:1'b1,
                   perturb:2, exp_shift:8, exp_fe:0, exp_brk:0, exp_len:176};
        tbl[2] = '{db:4'd8,  nd:8, par:1'b0, two:1'b0, data:8'hA5, pv:1'b0, s1:1'b0, s2:1'b1,
                   perturb:0, exp_shift:8, exp_fe:1, exp_brk:0, exp_len:160};
        tbl[3] = '{db:4'd5,  nd:5, par:1'b0, two:1'b1, data:8'h1F, pv:1'b0, s1:1'b1, s2:1'b0,
                   perturb:0, exp_shift:5, exp_fe:1, exp_brk:0, exp_len:128};
        tbl[4] = '{db:4'd12, nd:8, par:1'b1, two:1'b0, data:8'h00, pv:1'b0, s1:1'b0, s2:1'b1,
                   perturb:0, exp_shift:9, exp_fe:1, exp_brk:1, exp_len:176};
        tbl[5] = '{db:4'd6,  nd:6, par:1'b1, two:1'b0, data:8'h00, pv:1'b1, s1:1'b1, s2:1'b1,
                   perturb:0, exp_shift:7, exp_fe:0, exp_brk:0, exp_len:144};
        tbl[6] = '{db:4'd8,  nd:8, par:1'b0, two:1'b0, data:8'h3C, pv:1'b0, s1:1'b1, s2:1'b1,
                   perturb:0, exp_shift:8, exp_fe:0, exp_brk:0, exp_len:160};

        repeat (3) tick();
        chk("reset outputs",
            {busy, wait_bit_en, wait_bit_rst_n, shift_bits, done,
             framing_error, break_detect, false_start}, 0);
        rst = 1'b0;
        repeat (4) tick();

        for (int k = 0; k < 7; k++) run_vec(k);

        // Receiver disabled in IDLE: a falling edge must not start a frame.
        rx_enable = 1'b0;
        rx = 1'b1;
        repeat (4) tick();
        snapshot();
        rx = 1'b0;
        repeat (40) tick();
        chk("disabled no_start", start_total - s_start, 0);
        chk("disabled busy", busy, 0);
        rx = 1'b1;
        rx_enable = 1'b1;
        repeat (4) tick();

        // Line held low for 12 bit periods: break, then no restart while low.
        data_bits = 4'd8; parity_en = 1'b0; two_stop = 1'b0;
        line_bits = '0; nbits = 10; idle_level = 1'b0;
        rx = 1'b1;
        repeat (4) tick();
        snapshot();
        rx = 1'b0;
        tick();
        wait_done("break");
        chk("break done_count", done_total - s_done, 1);
        chk("break framing_error", fe_total - s_fe, 1);
        chk("break break_detect", brk_total - s_brk, 1);
        repeat (2 * PERIOD) tick();
        chk("break no_restart_low", start_total - s_start, 1);
        chk("break busy_low", busy, 0);
        rx = 1'b1;
        repeat (4) tick();
        run_vec(0);

        // Reset during data bit 3, then a clean frame.
        start_frame(tbl[6]);
        for (int i = 0; i < 200 && (shift_total - s_shift) < 3; i++) tick();
        chk("rst reached bit3", shift_total - s_shift, 3);
        repeat (5) tick();
        rst = 1'b1;
        rx  = 1'b1;
        tick();
        chk("rst outputs",
            {busy, wait_bit_en, wait_bit_rst_n, shift_bits, done,
             framing_error, break_detect, false_start}, 0);
        rst = 1'b0;
        repeat (40) tick();
        chk("rst no_done", done_total - s_done, 0);
        chk("rst no_error", (fe_total - s_fe) + (brk_total - s_brk), 0);
        run_vec(6);

`ifdef UART_RX_START_CHECK_EN
        // Two-cycle low glitch: start sample is 1, so it is rejected.
        rx = 1'b1;
        repeat (4) tick();
        line_bits = '0; line_bits[0] = 1'b1; nbits = 1; idle_level = 1'b1;
        snapshot();
        rx = 1'b0;
        tick();
        tick();
        rx = 1'b1;
        for (int i = 0; i < 100 && fs_total == s_fs; i++) tick();
        repeat (3) tick();
        chk("glitch false_start", fs_total - s_fs, 1);
        chk("glitch shifts", shift_total - s_shift, 0);
        chk("glitch done", done_total - s_done, 0);
        chk("glitch idle", {busy, wait_bit_rst_n}, 0);
`else
        chk("false_start tied", fs_total, 0);
`endif

        chk("strobe alignment", misalign, 0);
        chk("error without done", orphan, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
